// File: rtl/mem_fill_if.sv
// Cache-side and memory-side signal bundle for mem_fill_responder.
// The responder connects through the slave modport; cache and memory models use master.
interface mem_fill_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int WORD_BITS  = 3
);
    logic                  icache_req;
    logic [ADDR_WIDTH-1:0] icache_addr;
    logic                  dcache_req;
    logic [ADDR_WIDTH-1:0] dcache_addr;
    logic                  dcache_wr;
    logic [DATA_WIDTH-1:0] dcache_wr_data;

    logic                  icache_fill_valid;
    logic                  dcache_fill_valid;
    logic [DATA_WIDTH-1:0] fill_data;
    logic [WORD_BITS-1:0]  fill_word;
    logic                  icache_fill_done;
    logic                  dcache_fill_done;
    logic                  write_ack;

    logic                  mem_enable;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_data_valid;
    logic [DATA_WIDTH-1:0] mem_data_in;

    modport slave (
        input  icache_req, icache_addr, dcache_req, dcache_addr, dcache_wr, dcache_wr_data,
        input  mem_data_valid, mem_data_in,
        output icache_fill_valid, dcache_fill_valid, fill_data, fill_word,
        output icache_fill_done, dcache_fill_done, write_ack,
        output mem_enable, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output icache_req, icache_addr, dcache_req, dcache_addr, dcache_wr, dcache_wr_data,
        output mem_data_valid, mem_data_in,
        input  icache_fill_valid, dcache_fill_valid, fill_data, fill_word,
        input  icache_fill_done, dcache_fill_done, write_ack,
        input  mem_enable, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_fill_responder.sv
// Arbitrates I-cache fills, D-cache fills and D-cache write-through stores onto a
// pipelined main memory, streaming fill words back to whichever cache owns the fill.
//
// state | meaning
// IDLE  | sample requests (dcache_wr > dcache_req > icache_req) and latch owner/address
// WRITE | single-cycle store of dcache_wr_data, write_ack pulses
// FILL  | issue block reads back to back while forwarding returning words to the owner
module mem_fill_responder #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_fill_if.slave bus
);
    localparam int WORD_BITS      = $clog2(BLOCK_WORDS);
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT     = $clog2(BYTES_PER_WORD);
    localparam int BLOCK_BYTES    = BLOCK_WORDS * BYTES_PER_WORD;

    localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'(BLOCK_BYTES - 1);
    localparam logic [WORD_BITS:0]    ISSUE_END = (WORD_BITS + 1)'(BLOCK_WORDS);
    localparam logic [WORD_BITS-1:0]  LAST_WORD = WORD_BITS'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_BITS:0]    issue_cnt_q, issue_cnt_d;
    logic [WORD_BITS-1:0]  ret_cnt_q, ret_cnt_d;

    logic                  icache_fill_valid_c;
    logic                  dcache_fill_valid_c;
    logic [DATA_WIDTH-1:0] fill_data_c;
    logic [WORD_BITS-1:0]  fill_word_c;
    logic                  icache_fill_done_c;
    logic                  dcache_fill_done_c;
    logic                  write_ack_c;
    logic                  mem_enable_c;
    logic                  mem_wr_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;

    // Word offsets are OR-ed into the aligned base so the address can never carry out of the block.
    logic [ADDR_WIDTH-1:0] issue_off;
    assign issue_off = ADDR_WIDTH'(issue_cnt_q[WORD_BITS-1:0]) << BYTE_SHIFT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            addr_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        owner_d             = owner_q;
        addr_d              = addr_q;
        issue_cnt_d         = issue_cnt_q;
        ret_cnt_d           = ret_cnt_q;
        icache_fill_valid_c = 1'b0;
        dcache_fill_valid_c = 1'b0;
        fill_data_c         = '0;
        fill_word_c         = '0;
        icache_fill_done_c  = 1'b0;
        dcache_fill_done_c  = 1'b0;
        write_ack_c         = 1'b0;
        mem_enable_c        = 1'b0;
        mem_wr_c            = 1'b0;
        mem_addr_c          = '0;
        mem_wdata_c         = '0;

        case (state_q)
            IDLE: begin
                issue_cnt_d = '0;
                ret_cnt_d   = '0;
                if (bus.dcache_wr) begin
                    owner_d = OWN_D;
                    addr_d  = bus.dcache_addr;
                    state_d = WRITE;
                end else if (bus.dcache_req) begin
                    owner_d = OWN_D;
                    addr_d  = bus.dcache_addr & BASE_MASK;
                    state_d = FILL;
                end else if (bus.icache_req) begin
                    owner_d = OWN_I;
                    addr_d  = bus.icache_addr & BASE_MASK;
                    state_d = FILL;
                end
            end

            WRITE: begin
                mem_enable_c = 1'b1;
                mem_wr_c     = 1'b1;
                mem_addr_c   = addr_q;
                mem_wdata_c  = bus.dcache_wr_data;
                write_ack_c  = 1'b1;
                owner_d      = OWN_NONE;
                state_d      = IDLE;
            end

            FILL: begin
                if (issue_cnt_q < ISSUE_END) begin
                    mem_enable_c = 1'b1;
                    mem_addr_c   = addr_q | issue_off;
                    issue_cnt_d  = issue_cnt_q + 1'b1;
                end
                // Returns arrive in issue order, so ret_cnt is the word index of this beat.
                if (bus.mem_data_valid) begin
                    fill_data_c         = bus.mem_data_in;
                    fill_word_c         = ret_cnt_q;
                    icache_fill_valid_c = (owner_q == OWN_I);
                    dcache_fill_valid_c = (owner_q == OWN_D);
                    ret_cnt_d           = ret_cnt_q + 1'b1;
                    if (ret_cnt_q == LAST_WORD) begin
                        icache_fill_done_c = (owner_q == OWN_I);
                        dcache_fill_done_c = (owner_q == OWN_D);
                        owner_d            = OWN_NONE;
                        issue_cnt_d        = '0;
                        ret_cnt_d          = '0;
                        state_d            = IDLE;
                    end
                end
            end

            default: begin
                owner_d = OWN_NONE;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.icache_fill_valid = icache_fill_valid_c;
    assign bus.dcache_fill_valid = dcache_fill_valid_c;
    assign bus.fill_data         = fill_data_c;
    assign bus.fill_word         = fill_word_c;
    assign bus.icache_fill_done  = icache_fill_done_c;
    assign bus.dcache_fill_done  = dcache_fill_done_c;
    assign bus.write_ack         = write_ack_c;
    assign bus.mem_enable        = mem_enable_c;
    assign bus.mem_wr            = mem_wr_c;
    assign bus.mem_addr          = mem_addr_c;
    assign bus.mem_wdata         = mem_wdata_c;
endmodule

// File: tb/tb_mem_fill_responder.sv
// Scoreboard bench for mem_fill_responder: stimulus queues expected memory operations
// and fill beats, a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_fill_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mem_fill_if bus ();

    mem_fill_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          exp_cyc;
        int          gap;
    } mem_exp_t;

    typedef struct {
        logic        is_d;
        logic [2:0]  word;
        logic [15:0] data;
        logic        done;
    } fill_exp_t;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } ret_t;

    mem_exp_t  exp_mem[$];
    fill_exp_t exp_fill[$];
    ret_t      ret_pend[$];

    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int last_done_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    function automatic logic [63:0] all_outs();
        return {6'd0, bus.icache_fill_valid, bus.dcache_fill_valid, bus.fill_data, bus.fill_word,
                bus.icache_fill_done, bus.dcache_fill_done, bus.write_ack,
                bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_wdata};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Main memory: 4-cycle read latency, returns in issue order, mem[a] = a ^ A5A5.
    initial begin
        ret_t r;
        bus.mem_data_valid = 1'b0;
        bus.mem_data_in    = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_enable && !bus.mem_wr) ret_pend.push_back('{cyc + 4, bus.mem_addr});
            @(posedge clk);
            #1;
            if (ret_pend.size() != 0 && ret_pend[0].due == cyc) begin
                r = ret_pend.pop_front();
                bus.mem_data_valid = 1'b1;
                bus.mem_data_in    = mem_val(r.addr);
            end else begin
                bus.mem_data_valid = 1'b0;
                bus.mem_data_in    = '0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        mem_exp_t  me;
        fill_exp_t fe;
        if (rst_n) begin
            if (bus.mem_enable) begin
                if (exp_mem.size() == 0) begin
                    chk("unexpected_mem_access", {bus.mem_wr, bus.mem_addr}, 17'h1FFFF & 17'h0);
                end else begin
                    me = exp_mem.pop_front();
                    chk("mem_op", {bus.mem_wr, bus.write_ack, bus.mem_addr}, {me.wr, me.wr, me.addr});
                    if (me.wr) chk("mem_wdata", bus.mem_wdata, me.wdata);
                    if (me.exp_cyc >= 0) chk("mem_issue_cycle", 64'(cyc), 64'(me.exp_cyc));
                    if (me.gap >= 0) chk("gap_after_done", 64'(cyc - last_done_cyc), 64'(me.gap));
                end
            end else if (bus.write_ack) begin
                chk("write_ack_stray", bus.write_ack, 1'b0);
            end

            if (bus.icache_fill_valid || bus.dcache_fill_valid) begin
                if (exp_fill.size() == 0) begin
                    chk("unexpected_fill", {bus.icache_fill_valid, bus.dcache_fill_valid}, 2'b00);
                end else begin
                    fe = exp_fill.pop_front();
                    chk("fill_beat",
                        {bus.icache_fill_valid, bus.dcache_fill_valid, bus.fill_word, bus.fill_data,
                         bus.icache_fill_done, bus.dcache_fill_done},
                        {!fe.is_d, fe.is_d, fe.word, fe.data, fe.done && !fe.is_d, fe.done && fe.is_d});
                end
            end else if (bus.icache_fill_done || bus.dcache_fill_done) begin
                chk("done_without_fill", {bus.icache_fill_done, bus.dcache_fill_done}, 2'b00);
            end
            if (bus.icache_fill_done || bus.dcache_fill_done) last_done_cyc = cyc;
        end
    end

    // Cache-side behaviour: requests drop in the cycle their completion is seen.
    task automatic tick();
        @(negedge clk);
        if (bus.icache_fill_done) bus.icache_req = 1'b0;
        if (bus.dcache_fill_done) bus.dcache_req = 1'b0;
        if (bus.write_ack)        bus.dcache_wr  = 1'b0;
    endtask

    task automatic push_fill(input logic is_d, input logic [15:0] addr, input int first_cyc, input int gap);
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            exp_mem.push_back('{1'b0, base + 16'(2 * k), 16'h0000,
                                (first_cyc < 0) ? -1 : first_cyc + k, (k == 0) ? gap : -1});
            exp_fill.push_back('{is_d, 3'(k), mem_val(base + 16'(2 * k)), (k == 7)});
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_mem.size() != 0 || exp_fill.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_completed"}, 64'(n < budget), 64'd1);
        exp_mem.delete();
        exp_fill.delete();
        repeat (3) tick();
    endtask

    task automatic wait_beat(input logic is_d, input logic [2:0] word, input int budget);
        int n;
        n = 0;
        while (!((is_d ? bus.dcache_fill_valid : bus.icache_fill_valid) && bus.fill_word == word)
               && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("wait_beat_timeout", 64'(n), 64'(budget - 1));
    endtask

    initial begin
        int c;
        int stale_seen;
        bus.icache_req     = 1'b0;
        bus.icache_addr    = '0;
        bus.dcache_req     = 1'b0;
        bus.dcache_addr    = '0;
        bus.dcache_wr      = 1'b0;
        bus.dcache_wr_data = '0;
        rst_n = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_outputs", all_outs(), 64'd0);

        // I-fill of block 0x0120
        c = cyc;
        bus.icache_addr = 16'h0126;
        bus.icache_req  = 1'b1;
        push_fill(1'b0, 16'h0126, c + 1, -1);
        wait_beat(1'b0, 3'd0, 40);
        chk("ifill_word0_data", bus.fill_data, 16'hA485);
        wait_beat(1'b0, 3'd7, 40);
        chk("ifill_word7_done_data", {bus.icache_fill_done, bus.fill_data}, {1'b1, 16'hA48B});
        wait_drain("ifill", 40);

        // Store, D-fill and I-fill all requested together
        c = cyc;
        bus.dcache_wr      = 1'b1;
        bus.dcache_addr    = 16'h0040;
        bus.dcache_wr_data = 16'hBEEF;
        bus.dcache_req     = 1'b1;
        bus.icache_req     = 1'b1;
        bus.icache_addr    = 16'h0300;
        exp_mem.push_back('{1'b1, 16'h0040, 16'hBEEF, c + 1, -1});
        push_fill(1'b1, 16'h0200, c + 3, -1);
        push_fill(1'b0, 16'h0300, c + 16, 2);
        tick();
        chk("store_write_ack", {bus.write_ack, bus.mem_wr, bus.mem_addr}, {1'b1, 1'b1, 16'h0040});
        bus.dcache_addr = 16'h0200;
        wait_drain("priority", 80);

        // Top-of-memory block must not wrap to 0000
        c = cyc;
        bus.dcache_addr = 16'hFFFF;
        bus.dcache_req  = 1'b1;
        push_fill(1'b1, 16'hFFFF, c + 1, -1);
        wait_beat(1'b1, 3'd7, 40);
        chk("wrap_last_done", {bus.dcache_fill_done, bus.fill_data}, {1'b1, 16'hFFFE ^ 16'hA5A5});
        wait_drain("wrap", 40);

        // I-cache request arriving mid D-fill waits its turn
        c = cyc;
        bus.dcache_addr = 16'h0500;
        bus.dcache_req  = 1'b1;
        push_fill(1'b1, 16'h0500, c + 1, -1);
        push_fill(1'b0, 16'h0600, c + 14, 2);
        wait_beat(1'b1, 3'd2, 40);
        bus.icache_addr = 16'h0600;
        bus.icache_req  = 1'b1;
        wait_drain("busy_arrival", 80);

        // Requester drops dcache_req after word 1; fill still completes
        c = cyc;
        bus.dcache_addr = 16'h0808;
        bus.dcache_req  = 1'b1;
        push_fill(1'b1, 16'h0808, c + 1, -1);
        wait_beat(1'b1, 3'd1, 40);
        bus.dcache_req = 1'b0;
        wait_beat(1'b1, 3'd7, 40);
        chk("dropped_req_done", bus.dcache_fill_done, 1'b1);
        wait_drain("dropped_req", 40);

        // Reset in the middle of an I-fill
        c = cyc;
        bus.icache_addr = 16'h0700;
        bus.icache_req  = 1'b1;
        push_fill(1'b0, 16'h0700, c + 1, -1);
        wait_beat(1'b0, 3'd3, 40);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_midfill_outputs", all_outs(), 64'd0);
        exp_mem.delete();
        exp_fill.delete();
        bus.icache_req = 1'b0;
        tick();
        rst_n = 1'b1;
        stale_seen = 0;
        repeat (6) begin
            tick();
            if (bus.mem_data_valid) begin
                stale_seen++;
                chk("stale_return_ignored", {bus.icache_fill_valid, bus.dcache_fill_valid, bus.mem_enable}, 3'b000);
            end
        end
        chk("stale_returns_observed", 64'(stale_seen > 0), 64'd1);

        // Recovery: a fresh D-fill after the reset
        c = cyc;
        bus.dcache_addr = 16'h0A00;
        bus.dcache_req  = 1'b1;
        push_fill(1'b1, 16'h0A00, c + 1, -1);
        wait_drain("post_reset_fill", 40);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end
endmodule

// File: doc/mem_fill_responder.md
Name: mem_fill_responder

Overview:
- Memory-side responder for the I-cache and D-cache miss handlers.
- Accepts block-fill requests from both caches and single-word write-through stores from the D-cache.
- Arbitrates between them, drives a pipelined multi-cycle main memory, and streams fill words back to the requesting cache with a word index and a completion pulse.
- Sits between the two cache controllers inside cpu and the unified main-memory model.

Parameters:
- BLOCK_WORDS, 8, words per cache block (power of 2).
- ADDR_WIDTH, 16, byte address width.
- DATA_WIDTH, 16, word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- icache_req  in  1  I-cache fill request; held high until icache_fill_done.
- icache_addr  in  16  miss byte address; low 4 bits ignored.
- dcache_req  in  1  D-cache fill request; held high until dcache_fill_done.
- dcache_addr  in  16  D-cache miss or store byte address.
- dcache_wr  in  1  D-cache write-through request; held high until write_ack.
- dcache_wr_data  in  16  store data.
- icache_fill_valid  out  1  fill_data/fill_word valid for I-cache.
- dcache_fill_valid  out  1  fill_data/fill_word valid for D-cache.
- fill_data  out  16  returned memory word.
- fill_word  out  3  word index within block, 0..7.
- icache_fill_done  out  1  one-cycle pulse with last I-cache fill word.
- dcache_fill_done  out  1  one-cycle pulse with last D-cache fill word.
- write_ack  out  1  one-cycle pulse; store performed this cycle.
- mem_enable  out  1  memory access this cycle.
- mem_wr  out  1  write when mem_enable is high.
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_data_valid  in  1  memory read data returning (fixed pipeline latency, in issue order).
- mem_data_in  in  16  memory read data.

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE; issue and return counters = 0; owner = none.
  - All outputs 0; fill_data = 0.
- States: IDLE, WRITE, FILL.
- IDLE: sample requests each rising edge. Priority is dcache_wr > dcache_req > icache_req.
  - Winner recorded as owner. Go to WRITE (store) or FILL (fill).
  - Block base = addr & 16'hFFF0 is latched.
- WRITE (1 cycle):
  - mem_enable = 1, mem_wr = 1, mem_addr = latched addr, mem_wdata = dcache_wr_data, write_ack = 1.
  - Next state is IDLE.
- FILL, issue phase:
  - For issue_cnt 0..7 on consecutive cycles: mem_enable = 1, mem_wr = 0, mem_addr = base + 2*issue_cnt.
  - mem_enable = 0 after 8 issues.
- FILL, return phase (overlaps the issue phase):
  - Each cycle mem_data_valid = 1: fill_data = mem_data_in, fill_word = ret_cnt, owner's *_fill_valid = 1, ret_cnt increments.
  - These outputs are combinational from mem_data_valid; no added latency.
- Completion: when ret_cnt == 7 and mem_data_valid, the owner's *_fill_done pulses in the same cycle. Next state is IDLE and counters clear.
- Latency: request seen at edge N, first address issued in cycle N+1. Minimum gap between back-to-back transactions is one IDLE cycle.
- Non-owner outputs: the non-owner's fill_valid and fill_done stay 0 throughout.
- Requests during WRITE/FILL: not sampled; they wait in IDLE per priority. The I-cache can starve only while D-cache traffic is continuous.
- Requester drops req mid-fill: the fill completes normally and the done pulse is still issued.
- mem_data_valid in IDLE or WRITE: ignored; no fill_valid.
- Address arithmetic: base + 2*k never carries out of the block, so base 16'hFFF0 issues FFF0..FFFE with no wrap.
- Reset asserted mid-fill: immediate return to reset values. Outstanding memory returns after reset are ignored (IDLE).

Test Plan:
- Reset: rst_n = 0 mid-FILL at word 3 -> all outputs 0 immediately; after release state is IDLE; the stale mem_data_valid the model still returns 2 cycles later does not raise icache_fill_valid.
- I-fill: bench memory has 4-cycle latency with mem[a] = a ^ 16'hA5A5; icache_req with addr 16'h0126 -> mem_addr 0120,0122,..,012E on 8 consecutive cycles; fill_word 0..7 with fill_data 0120^A5A5.. (first = 16'hA485); icache_fill_done coincides with word 7 (0x012E^A5A5 = 16'hA48B).
- Priority: dcache_wr (addr 16'h0040, data 16'hBEEF), dcache_req (16'h0200) and icache_req (16'h0300) asserted in the same cycle -> order is store (write_ack, mem_wr = 1, mem_addr 0040, mem_wdata BEEF), then D-fill of 0200..020E, then I-fill of 0300..030E; no fill_valid crosses to the wrong cache.
- Wrap boundary: dcache_req addr 16'hFFFF -> addresses FFF0..FFFE; dcache_fill_done after 8 words; no address 0000 issued.
- Busy arrival: icache_req arrives during a D-fill word 2 -> ignored until the D-fill finishes; I-fill begins issuing 2 cycles after dcache_fill_done.
- Dropped request: dcache_req deasserted after word 1 -> words 2..7 still returned; dcache_fill_done still pulses once.
